bus_grant_controller: RTL and testbench
=======================================

// Module: bus_grant_controller
// PURPOSE
// - Shares one downstream bus port among PORT_COUNT masters using rotating-priority arbitration.
// - A grant is held for a whole burst, from the first beat to the beat that carries req_last_i.
// - Outputs are control only: grant_o and grant_id_o drive the external data/address mux in the soc2 interconnect.
// PARAMETERS
// - PORT_COUNT      8    number of requesting masters (>=2)
// - PORT_ID_WIDTH   $clog2(PORT_COUNT)   width of grant_id_o
// - TIMEOUT_CYCLES  256  idle cycles in OWN before forced release (used only with BUS_GRANT_TIMEOUT_EN)
// - TMO_WIDTH       $clog2(TIMEOUT_CYCLES+1)   width of the idle counter
// PORTS
// - clk_i          in   1              clock; all logic on the rising edge
// - reset_i        in   1              synchronous, active-high reset
// - req_valid_i    in   PORT_COUNT     per-master request/beat valid
// - req_last_i     in   PORT_COUNT     per-master final-beat marker; qualified by req_valid_i
// - bus_ready_i    in   1              downstream accepts a beat this cycle
// - grant_o        out  PORT_COUNT     one-hot grant, registered
// - grant_id_o     out  PORT_ID_WIDTH  binary index of the owner, registered
// - grant_valid_o  out  1              a master currently owns the bus
// - timeout_o      out  1              one-cycle pulse on forced release
// BEHAVIOUR
// - Reset values: grant_o=0, grant_id_o=0, grant_valid_o=0, timeout_o=0, priority pointer ptr=0, idle counter=0, state=IDLE.
// - Reset taken mid-burst drops the grant in the next cycle; no beat completes.
// - Beat: the cycle where grant_valid_o && req_valid_i[grant_id_o] && bus_ready_i.
// - Last beat: a beat where req_last_i[grant_id_o] is also 1.
// - Pick: search req_valid_i from index ptr upward, wrapping at PORT_COUNT-1 -> 0. The first set bit wins.
// - States:
//   - IDLE: no requests -> stay. Any request -> register the pick; go to OWN. The grant appears the cycle after the request (1-cycle latency).
//   - OWN: grant is held whether or not the owner keeps req_valid_i high (lock). Requests from other masters are ignored.
//     - On the last beat: ptr <= (grant_id_o+1) mod PORT_COUNT.
//     - Same cycle, other requests pending: pick among them (the owner is excluded) and register the new grant. Back-to-back handover, no idle cycle.
//     - Same cycle, no other requests: drop to IDLE; grant_o=0 next cycle.
// - A single-beat burst (req_last_i=1 on the first beat) is legal and releases that same cycle.
// - A sole requester that issues back-to-back bursts is re-granted. It passes through IDLE, giving 1 idle cycle between bursts.
// - ptr advances only on release (last beat or timeout), never on grant.
// - Modular index math is done at PORT_ID_WIDTH+1 bits and then reduced. This covers non-power-of-2 PORT_COUNT; indices >= PORT_COUNT are never granted.
// - grant_o and grant_id_o always agree, both are updated in the same register stage, and grant_o is 0 when grant_valid_o=0.
// CONFIGURATION
// - Macro: BUS_GRANT_TIMEOUT_EN.
// - Defined:
//   - The idle counter increments in OWN on every cycle without a beat and clears on any beat or on a new grant.
//   - When the counter reaches TIMEOUT_CYCLES: force release, pulse timeout_o for 1 cycle, advance ptr past the owner, and re-arbitrate as on a last beat.
// - Undefined: no counter is built, timeout_o is tied 0, and a stalled owner holds the bus indefinitely.
// STRUCTURE
// - Package soc2_arb_pkg:
//   - typedef enum logic [0:0] {ARB_IDLE, ARB_OWN} arb_state_e
//   - function rr_next_idx() for the modular increment
// - Sub-module rr_pick (combinational):
//   - inputs: req vector, ptr, exclude mask
//   - outputs: found flag, binary index
//   - instantiated once; it holds no state.
// - Top: state register, ptr register, grant registers, optional idle counter.
// TESTING
// - PORT_COUNT=8:
//   - After reset, req_valid_i=8'h24 -> grant_id_o=2 one cycle later.
//   - Last beat on 2, with 5 still requesting -> grant_id_o=5 in the next cycle, grant_valid_o stays 1.
// - Lock: owner 3 drops req_valid_i for 10 cycles while 8'hF0 requests -> grant stays on 3. Last beat on 3 -> grant moves to 4.
// - Wrap: ptr=7 (owner 6 just released) with requests 8'h41 -> grant 0 (index 7 has no request, search wraps to 0), not 6.
// - Fairness: all 8 masters send continuous single-beat bursts with bus_ready_i=1 -> grants run 0,1,...,7,0. Each master gets exactly 1 grant per 8 consecutive grants.
// - Reset mid-burst: reset_i=1 while owner 4 is holding -> next cycle grant_o=0 and ptr=0. The first request after reset follows the pick from index 0.
// - With BUS_GRANT_TIMEOUT_EN, TIMEOUT_CYCLES=16:
//   - Owner 1 stalls (bus_ready_i=0) -> timeout_o pulses after 16 idle cycles.
//   - Pending master 2 is then granted in the next cycle.
// - Without the macro: same stall -> timeout_o stays 0 and the grant holds for 1000 cycles.

Source files
------------

// File: rtl/soc2_arb_pkg.sv
// Shared types and index helpers for the soc2 bus grant controller.
package soc2_arb_pkg;

    typedef enum logic [0:0] {ARB_IDLE, ARB_OWN} arb_state_e;

    // Index one past idx, wrapping at count (count need not be a power of two).
    function automatic int rr_next_idx(input int idx, input int count);
        return (idx + 1 >= count) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority search: first eligible request at or after ptr, wrapping.
module rr_pick #(
    parameter int PORT_COUNT    = 8,
    parameter int PORT_ID_WIDTH = $clog2(PORT_COUNT)
) (
    input  logic [PORT_COUNT-1:0]    req,
    input  logic [PORT_ID_WIDTH-1:0] ptr,
    input  logic [PORT_COUNT-1:0]    exclude,
    output logic                     found,
    output logic [PORT_ID_WIDTH-1:0] idx
);

    localparam int IW = PORT_ID_WIDTH + 1;

    logic [PORT_COUNT-1:0] eligible;
    logic [IW-1:0]         cand;

    assign eligible = req & ~exclude;

    // One extra bit on the candidate keeps ptr+i from overflowing before the wrap.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            cand = {1'b0, ptr} + IW'(i);
            if (cand >= IW'(PORT_COUNT)) begin
                cand = cand - IW'(PORT_COUNT);
            end
            if (!found && eligible[cand[PORT_ID_WIDTH-1:0]]) begin
                found = 1'b1;
                idx   = cand[PORT_ID_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_grant_controller.sv
// Burst-locked rotating-priority arbiter for one downstream bus port.
// Optional stall watchdog enabled by defining BUS_GRANT_TIMEOUT_EN.
module bus_grant_controller
    import soc2_arb_pkg::*;
#(
    parameter int PORT_COUNT     = 8,
    parameter int PORT_ID_WIDTH  = $clog2(PORT_COUNT),
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TMO_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [PORT_COUNT-1:0]    req_valid_i,
    input  logic [PORT_COUNT-1:0]    req_last_i,
    input  logic                     bus_ready_i,
    output logic [PORT_COUNT-1:0]    grant_o,
    output logic [PORT_ID_WIDTH-1:0] grant_id_o,
    output logic                     grant_valid_o,
    output logic                     timeout_o
);

    localparam logic [PORT_COUNT-1:0] ONE_HOT_0 = {{(PORT_COUNT-1){1'b0}}, 1'b1};

    arb_state_e               state;
    logic [PORT_ID_WIDTH-1:0] ptr;
    logic [PORT_ID_WIDTH-1:0] ptr_rel;
    logic [PORT_ID_WIDTH-1:0] pick_ptr;
    logic [PORT_ID_WIDTH-1:0] pick_idx;
    logic [PORT_COUNT-1:0]    pick_excl;
    logic                     pick_found;
    logic                     beat;
    logic                     last_beat;
    logic                     tmo_hit;
    logic                     release_own;

    assign beat        = grant_valid_o && req_valid_i[grant_id_o] && bus_ready_i;
    assign last_beat   = beat && req_last_i[grant_id_o];
    assign release_own = last_beat || tmo_hit;
    assign ptr_rel     = PORT_ID_WIDTH'(rr_next_idx(int'(grant_id_o), PORT_COUNT));

    // On release the search already starts past the owner, and the owner is masked out.
    assign pick_ptr  = (state == ARB_OWN) ? ptr_rel : ptr;
    assign pick_excl = (state == ARB_OWN) ? grant_o : '0;

    rr_pick #(
        .PORT_COUNT    (PORT_COUNT),
        .PORT_ID_WIDTH (PORT_ID_WIDTH)
    ) u_pick (
        .req     (req_valid_i),
        .ptr     (pick_ptr),
        .exclude (pick_excl),
        .found   (pick_found),
        .idx     (pick_idx)
    );

`ifdef BUS_GRANT_TIMEOUT_EN
    logic [TMO_WIDTH-1:0] idle_cnt;

    assign tmo_hit = (state == ARB_OWN) && (idle_cnt == TMO_WIDTH'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            idle_cnt <= '0;
        end else if (state != ARB_OWN || beat || release_own) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    logic unused_tmo_cfg;

    assign tmo_hit        = 1'b0;
    assign unused_tmo_cfg = ^TMO_WIDTH'(TIMEOUT_CYCLES);
`endif

    // Grant stage: state, pointer and all grant outputs update on the same edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state         <= ARB_IDLE;
            ptr           <= '0;
            grant_o       <= '0;
            grant_id_o    <= '0;
            grant_valid_o <= 1'b0;
            timeout_o     <= 1'b0;
        end else begin
            timeout_o <= tmo_hit && !last_beat;
            unique case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        state         <= ARB_OWN;
                        grant_o       <= ONE_HOT_0 << pick_idx;
                        grant_id_o    <= pick_idx;
                        grant_valid_o <= 1'b1;
                    end
                end
                ARB_OWN: begin
                    if (release_own) begin
                        ptr <= ptr_rel;
                        if (pick_found) begin
                            grant_o    <= ONE_HOT_0 << pick_idx;
                            grant_id_o <= pick_idx;
                        end else begin
                            state         <= ARB_IDLE;
                            grant_o       <= '0;
                            grant_id_o    <= '0;
                            grant_valid_o <= 1'b0;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_grant_controller.sv
// Directed bench for bus_grant_controller; covers the timeout build when BUS_GRANT_TIMEOUT_EN is defined.
module tb_bus_grant_controller;

`ifdef BUS_GRANT_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 256;
`endif

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic [7:0] req_valid_i = '0;
    logic [7:0] req_last_i = '0;
    logic       bus_ready_i = 1'b1;
    logic [7:0] grant_o;
    logic [2:0] grant_id_o;
    logic       grant_valid_o;
    logic       timeout_o;

    int checks = 0;
    int failures = 0;

    bus_grant_controller #(
        .PORT_COUNT     (8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .req_valid_i   (req_valid_i),
        .req_last_i    (req_last_i),
        .bus_ready_i   (bus_ready_i),
        .grant_o       (grant_o),
        .grant_id_o    (grant_id_o),
        .grant_valid_o (grant_valid_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i     = 1'b1;
        req_valid_i = '0;
        req_last_i  = '0;
        bus_ready_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (grant_o !== 8'h00) begin
            failures++;
            $display("FAIL reset_grant: got %h expected 00", grant_o);
        end
        checks++;
        if (grant_id_o !== 3'd0) begin
            failures++;
            $display("FAIL reset_grant_id: got %0d expected 0", grant_id_o);
        end
        checks++;
        if (grant_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid: got %b expected 0", grant_valid_o);
        end
        checks++;
        if (timeout_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_timeout: got %b expected 0", timeout_o);
        end
    endtask

    task automatic test_handover();
        do_reset();
        req_valid_i = 8'h24;
        tick();
        checks++;
        if (grant_id_o !== 3'd2 || grant_o !== 8'h04 || grant_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL first_grant: got id=%0d oh=%h v=%b expected id=2 oh=04 v=1",
                     grant_id_o, grant_o, grant_valid_o);
        end
        req_last_i = 8'h04;
        tick();
        checks++;
        if (grant_id_o !== 3'd5 || grant_o !== 8'h20 || grant_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL handover: got id=%0d oh=%h v=%b expected id=5 oh=20 v=1",
                     grant_id_o, grant_o, grant_valid_o);
        end
        req_valid_i = 8'h20;
        req_last_i  = 8'h20;
        tick();
        checks++;
        if (grant_valid_o !== 1'b0 || grant_o !== 8'h00) begin
            failures++;
            $display("FAIL drop_idle: got oh=%h v=%b expected oh=00 v=0", grant_o, grant_valid_o);
        end
        req_valid_i = '0;
        req_last_i  = '0;
    endtask

    task automatic test_lock();
        do_reset();
        req_valid_i = 8'h08;
        tick();
        checks++;
        if (grant_id_o !== 3'd3) begin
            failures++;
            $display("FAIL lock_grant: got %0d expected 3", grant_id_o);
        end
        req_valid_i = 8'hF0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (grant_id_o !== 3'd3 || grant_valid_o !== 1'b1) begin
                failures++;
                $display("FAIL lock_hold[%0d]: got id=%0d v=%b expected id=3 v=1",
                         i, grant_id_o, grant_valid_o);
            end
        end
        req_valid_i = 8'hF8;
        req_last_i  = 8'h08;
        tick();
        checks++;
        if (grant_id_o !== 3'd4 || grant_o !== 8'h10) begin
            failures++;
            $display("FAIL lock_release: got id=%0d oh=%h expected id=4 oh=10", grant_id_o, grant_o);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req_valid_i = 8'h40;
        tick();
        checks++;
        if (grant_id_o !== 3'd6) begin
            failures++;
            $display("FAIL wrap_owner: got %0d expected 6", grant_id_o);
        end
        req_valid_i = 8'h41;
        req_last_i  = 8'h40;
        tick();
        checks++;
        if (grant_id_o !== 3'd0 || grant_o !== 8'h01 || grant_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL wrap_pick: got id=%0d oh=%h v=%b expected id=0 oh=01 v=1",
                     grant_id_o, grant_o, grant_valid_o);
        end
    endtask

    task automatic test_fairness();
        int seen[8];
        int exp_id;
        for (int k = 0; k < 8; k++) seen[k] = 0;
        do_reset();
        req_valid_i = 8'hFF;
        req_last_i  = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            exp_id = i % 8;
            checks++;
            if (grant_id_o !== 3'(exp_id) || grant_valid_o !== 1'b1) begin
                failures++;
                $display("FAIL fair_seq[%0d]: got id=%0d v=%b expected id=%0d v=1",
                         i, grant_id_o, grant_valid_o, exp_id);
            end
            if (i < 8) seen[grant_id_o]++;
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (seen[k] != 1) begin
                failures++;
                $display("FAIL fair_count[%0d]: got %0d grants expected 1", k, seen[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_valid_i = 8'h08;
        req_last_i  = 8'h08;
        tick();
        checks++;
        if (grant_id_o !== 3'd3 || grant_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first: got id=%0d v=%b expected id=3 v=1", grant_id_o, grant_valid_o);
        end
        tick();
        checks++;
        if (grant_valid_o !== 1'b0 || grant_o !== 8'h00) begin
            failures++;
            $display("FAIL b2b_gap: got oh=%h v=%b expected oh=00 v=0", grant_o, grant_valid_o);
        end
        tick();
        checks++;
        if (grant_id_o !== 3'd3 || grant_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_regrant: got id=%0d v=%b expected id=3 v=1", grant_id_o, grant_valid_o);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_valid_i = 8'h10;
        req_last_i  = 8'h10;
        tick();
        req_last_i = 8'h00;
        tick();
        tick();
        checks++;
        if (grant_id_o !== 3'd4 || grant_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL mid_owner: got id=%0d v=%b expected id=4 v=1", grant_id_o, grant_valid_o);
        end
        reset_i = 1'b1;
        tick();
        checks++;
        if (grant_o !== 8'h00 || grant_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_drop: got oh=%h v=%b expected oh=00 v=0", grant_o, grant_valid_o);
        end
        reset_i     = 1'b0;
        req_valid_i = 8'h21;
        tick();
        checks++;
        if (grant_id_o !== 3'd0 || grant_o !== 8'h01) begin
            failures++;
            $display("FAIL mid_ptr_cleared: got id=%0d oh=%h expected id=0 oh=01", grant_id_o, grant_o);
        end
    endtask

    task automatic test_stall();
        do_reset();
        req_valid_i = 8'h02;
        tick();
        checks++;
        if (grant_id_o !== 3'd1) begin
            failures++;
            $display("FAIL stall_owner: got %0d expected 1", grant_id_o);
        end
        bus_ready_i = 1'b0;
        req_valid_i = 8'h06;
`ifdef BUS_GRANT_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if (timeout_o !== 1'b0 || grant_id_o !== 3'd1) begin
                failures++;
                $display("FAIL tmo_early[%0d]: got tmo=%b id=%0d expected tmo=0 id=1",
                         i, timeout_o, grant_id_o);
            end
        end
        tick();
        checks++;
        if (timeout_o !== 1'b1 || grant_id_o !== 3'd2 || grant_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL tmo_fire: got tmo=%b id=%0d v=%b expected tmo=1 id=2 v=1",
                     timeout_o, grant_id_o, grant_valid_o);
        end
        tick();
        checks++;
        if (timeout_o !== 1'b0) begin
            failures++;
            $display("FAIL tmo_pulse_width: got %b expected 0", timeout_o);
        end
`else
        for (int i = 0; i < 1000; i++) begin
            tick();
            checks++;
            if (timeout_o !== 1'b0 || grant_id_o !== 3'd1 || grant_valid_o !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got tmo=%b id=%0d v=%b expected tmo=0 id=1 v=1",
                         i, timeout_o, grant_id_o, grant_valid_o);
            end
        end
`endif
        bus_ready_i = 1'b1;
        req_valid_i = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_handover();
        test_lock();
        test_wrap();
        test_fairness();
        test_back_to_back();
        test_reset_mid_burst();
        test_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
